// File: rtl/ip_sync_axil_slave_regs.sv
// rtl/ip_sync_axil_slave_regs.sv - AXI4-Lite register slave for IP_sync
// NUM_REGS x 32-bit control/status registers with per-register write strobes.
module ip_sync_axil_slave_regs #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 6,
   parameter int          NUM_REGS           = 4,
   parameter logic [31:0] RESET_VAL          = 32'h0
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [32*NUM_REGS-1:0]          reg_out,
   output logic [NUM_REGS-1:0]             reg_wr_stb
);

   localparam int IW = $clog2(NUM_REGS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   w_state_e                        w_state_q, w_state_d;
   r_state_e                        r_state_q, r_state_d;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [31:0]                     wdata_q, wdata_d;
   logic [3:0]                      wstrb_q, wstrb_d;
   logic                            awready_q, awready_d;
   logic                            wready_q, wready_d;
   logic                            bvalid_q, bvalid_d;
   logic [1:0]                      bresp_q, bresp_d;
   logic                            arready_q, arready_d;
   logic                            rvalid_q, rvalid_d;
   logic [31:0]                     rdata_q, rdata_d;
   logic [1:0]                      rresp_q, rresp_d;
   logic [NUM_REGS-1:0][31:0]       regs_q, regs_d;
   logic [NUM_REGS-1:0]             stb_q, stb_d;

   logic                            aw_hs, w_hs, commit;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
   logic [31:0]                     wr_data;
   logic [3:0]                      wr_strb;
   logic [IW-1:0]                   wr_idx, rd_idx;
   logic                            unused_ok;

   // Any set bit above the register index field means out of range.
   function automatic logic addr_oor(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
      return (a >> (2 + IW)) != '0;
   endfunction

   assign aw_hs   = awready_q && S_AXI_AWVALID;
   assign w_hs    = wready_q && S_AXI_WVALID;
   assign wr_addr = (w_state_q == W_HAVE_AW) ? awaddr_q : S_AXI_AWADDR;
   assign wr_data = (w_state_q == W_HAVE_W) ? wdata_q : S_AXI_WDATA;
   assign wr_strb = (w_state_q == W_HAVE_W) ? wstrb_q : S_AXI_WSTRB;
   assign wr_idx  = wr_addr[2 +: IW];
   assign rd_idx  = S_AXI_ARADDR[2 +: IW];
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      regs_d    = regs_q;
      stb_d     = '0;
      commit    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
            end else if (aw_hs) begin
               w_state_d = W_HAVE_AW;
               awaddr_d  = S_AXI_AWADDR;
            end else if (w_hs) begin
               w_state_d = W_HAVE_W;
               wdata_d   = S_AXI_WDATA;
               wstrb_d   = S_AXI_WSTRB;
            end
         end
         W_HAVE_AW: commit = w_hs;
         W_HAVE_W:  commit = aw_hs;
         W_RESP: begin
            if (S_AXI_BREADY) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      if (commit) begin
         w_state_d = W_RESP;
         bvalid_d  = 1'b1;
         if (addr_oor(wr_addr)) begin
            bresp_d = RESP_SLVERR;
         end else begin
            bresp_d        = RESP_OKAY;
            stb_d[wr_idx]  = 1'b1;
            for (int b = 0; b < 4; b++) begin
               if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end
      awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
      wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
   end

   // Reads sample regs_q, so a same-edge write to the same index returns the old value.
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (arready_q && S_AXI_ARVALID) begin
               r_state_d = R_DATA;
               rvalid_d  = 1'b1;
               if (addr_oor(S_AXI_ARADDR)) begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end else begin
                  rdata_d = regs_q[rd_idx];
                  rresp_d = RESP_OKAY;
               end
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) begin
               r_state_d = R_IDLE;
               rvalid_d  = 1'b0;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         regs_q    <= {NUM_REGS{RESET_VAL}};
         stb_q     <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         regs_q    <= regs_d;
         stb_q     <= stb_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign reg_out       = regs_q;
   assign reg_wr_stb    = stb_q;

endmodule
